// File: rtl/instr_fetch_sequencer_pkg.sv
// rtl/instr_fetch_sequencer_pkg.sv - shared opcode definitions and instruction field helpers
package instr_fetch_sequencer_pkg;

    localparam int OPCODE_MSB = 27;
    localparam int OPCODE_LSB = 24;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LED  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [27:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// rtl/instr_fetch_sequencer_if.sv - ROM, decode-handshake, branch and counter signals of the fetch sequencer
interface instr_fetch_sequencer_if;

    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;
    logic [27:0] oInstruction;
    logic [15:0] oPC;
    logic        oValid;
    logic        iReady;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oHalted;
    logic [31:0] oFetchCount;
    logic [31:0] oStallCount;

    modport master (
        output oRomAddress, oInstruction, oPC, oValid, oHalted, oFetchCount, oStallCount,
        input  iRomInstruction, iReady, iBranchTaken, iBranchTarget
    );

    modport slave (
        input  oRomAddress, oInstruction, oPC, oValid, oHalted, oFetchCount, oStallCount,
        output iRomInstruction, iReady, iBranchTaken, iBranchTarget
    );

endinterface

// File: rtl/instr_fetch_sequencer_perf.sv
// rtl/instr_fetch_sequencer_perf.sv - saturating fetch/stall counters, present only with IFETCH_PERF_CNT_EN
module instr_fetch_sequencer_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        ready,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (valid && ready && fetch_count != 32'hFFFF_FFFF)
                fetch_count <= fetch_count + 32'd1;
            if (valid && !ready && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, valid, ready};
    assign fetch_count   = 32'd0;
    assign stall_count   = 32'd0;
`endif

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - ROM fetch sequencer with decode handshake, branch redirect and halt drain
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'd0,
    parameter logic [3:0]  HALT_OPCODE  = OP_HALT
) (
    input  logic                        Clock,
    input  logic                        Reset,
    instr_fetch_sequencer_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] opc_q, opc_d;
    logic [27:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            opc_q   <= 16'd0;
            instr_q <= 28'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (!valid_q || bus.iReady) begin
                    instr_d = bus.iRomInstruction;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    // The halt word is presented but PC stays on it, so the ROM address freezes there.
                    if (opcode_of(bus.iRomInstruction) == HALT_OPCODE)
                        state_d = DRAIN;
                    else
                        pc_d = pc_q + 16'd1;
                end
            end
            DRAIN: begin
                if (valid_q && bus.iReady) begin
                    valid_d = 1'b0;
                    state_d = HALTED;
                end
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase
        // A redirect wins over everything; any presented word is dropped or already accepted.
        if (bus.iBranchTaken && state_q != IDLE) begin
            pc_d    = bus.iBranchTarget;
            valid_d = 1'b0;
            state_d = RUN;
        end
    end

    assign bus.oRomAddress  = pc_q;
    assign bus.oInstruction = instr_q;
    assign bus.oPC          = opc_q;
    assign bus.oValid       = valid_q;
    assign bus.oHalted      = (state_q == HALTED);

    instr_fetch_sequencer_perf u_perf (
        .clk         (Clock),
        .rst         (Reset),
        .valid       (valid_q),
        .ready       (bus.iReady),
        .fetch_count (bus.oFetchCount),
        .stall_count (bus.oStallCount)
    );

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - self-checking bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;
    import instr_fetch_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic halt_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   seen6 = 1'b0;

`ifdef IFETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_fetch_sequencer_if bus1();
    instr_fetch_sequencer_if bus2();

    instr_fetch_sequencer #(.RESET_VECTOR(16'd0)) dut1 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus1)
    );

    instr_fetch_sequencer #(.RESET_VECTOR(16'hFFFE)) dut2 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus2)
    );

    // ROM image: ADD everywhere, carrying its own address; optionally a HALT at address 4.
    function automatic logic [27:0] rom_word(input logic [15:0] a, input logic h);
        logic [3:0] op;
        op = (h && a == 16'd4) ? OP_HALT : OP_ADD;
        return {op, 8'h5A, a};
    endfunction

    always_comb bus1.iRomInstruction = rom_word(bus1.oRomAddress, halt_en);
    always_comb bus2.iRomInstruction = rom_word(bus2.oRomAddress, 1'b0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model of dut1: what the decode side must observe.
    logic [15:0] m_pc;
    logic [15:0] m_opc;
    logic [27:0] m_instr;
    bit          m_valid, m_fresh, m_drain, m_halted;
    int unsigned m_fetch, m_stall;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 16'd0; m_opc = 16'd0; m_instr = 28'd0;
            m_valid = 0; m_fresh = 1; m_drain = 0; m_halted = 0;
            m_fetch = 0; m_stall = 0;
        end else begin
            if (m_valid && bus1.iReady && m_fetch != 32'hFFFF_FFFF) m_fetch++;
            if (m_valid && !bus1.iReady && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (m_fresh) begin
                m_fresh = 0;
            end else if (bus1.iBranchTaken) begin
                m_pc = bus1.iBranchTarget; m_valid = 0; m_drain = 0; m_halted = 0;
            end else if (m_halted) begin
                m_halted = 1;
            end else if (m_drain) begin
                if (m_valid && bus1.iReady) begin
                    m_valid = 0; m_drain = 0; m_halted = 1;
                end
            end else if (!m_valid || bus1.iReady) begin
                m_instr = rom_word(m_pc, halt_en);
                m_opc   = m_pc;
                m_valid = 1;
                if (m_instr[27:24] == OP_HALT) m_drain = 1;
                else m_pc = m_pc + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 64'(bus1.oValid), 64'(m_valid));
        chk("m_halted", 64'(bus1.oHalted), 64'(m_halted));
        chk("m_romaddr", 64'(bus1.oRomAddress), 64'(m_pc));
        chk("m_fetchcnt", 64'(bus1.oFetchCount), PERF ? 64'(m_fetch) : 64'd0);
        chk("m_stallcnt", 64'(bus1.oStallCount), PERF ? 64'(m_stall) : 64'd0);
        if (m_valid || rst) begin
            chk("m_instr", 64'(bus1.oInstruction), 64'(m_instr));
            chk("m_pc", 64'(bus1.oPC), 64'(m_opc));
        end
        if (bus1.oValid && bus1.oPC == 16'd6) seen6 = 1'b1;
    end

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus1.oValid), 64'd0);
        chk({tag, "_pc"}, 64'(bus1.oPC), 64'd0);
        chk({tag, "_instr"}, 64'(bus1.oInstruction), 64'd0);
        chk({tag, "_romaddr"}, 64'(bus1.oRomAddress), 64'd0);
        chk({tag, "_halted"}, 64'(bus1.oHalted), 64'd0);
        chk({tag, "_fetchcnt"}, 64'(bus1.oFetchCount), 64'd0);
        chk({tag, "_stallcnt"}, 64'(bus1.oStallCount), 64'd0);
        chk({tag, "_dut2_romaddr"}, 64'(bus2.oRomAddress), 64'hFFFE);
    endtask

    initial begin
        bus1.iReady = 1'b1; bus1.iBranchTaken = 1'b0; bus1.iBranchTarget = 16'd0;
        bus2.iReady = 1'b1; bus2.iBranchTaken = 1'b0; bus2.iBranchTarget = 16'd0;
        #1 rst = 1'b1;
        nedge(1);
        chk_reset_outputs("rst0");
        @(posedge clk); #2 rst = 1'b0;

        // IDLE cycle, then linear fetch on both instances
        nedge(2);
        chk("idle_valid", 64'(bus1.oValid), 64'd0);
        chk("idle_valid2", 64'(bus2.oValid), 64'd0);
        nedge(1);
        chk("first_valid", 64'(bus1.oValid), 64'd1);
        chk("first_pc", 64'(bus1.oPC), 64'd0);
        chk("rv_pc0", 64'(bus2.oPC), 64'hFFFE);
        nedge(1);
        chk("lin_pc1", 64'(bus1.oPC), 64'd1);
        chk("rv_pc1", 64'(bus2.oPC), 64'hFFFF);
        nedge(1);
        chk("lin_pc2", 64'(bus1.oPC), 64'd2);
        chk("lin_instr2", 64'(bus1.oInstruction), 64'h25A0002);
        chk("rv_wrap", 64'(bus2.oPC), 64'h0000);
        chk("rv_valid", 64'(bus2.oValid), 64'd1);

        // three stall cycles at address 2
        bus1.iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nedge(1);
            chk("stall_pc", 64'(bus1.oPC), 64'd2);
            chk("stall_valid", 64'(bus1.oValid), 64'd1);
        end
        bus1.iReady = 1'b1;
        nedge(1);
        chk("resume_pc", 64'(bus1.oPC), 64'd3);
        chk("stall_cnt", 64'(bus1.oStallCount), PERF ? 64'd3 : 64'd0);
        chk("fetch_cnt", 64'(bus1.oFetchCount), PERF ? 64'd3 : 64'd0);
        nedge(2);
        chk("pre_branch_pc", 64'(bus1.oPC), 64'd5);

        // branch with coincident ready while address 5 is presented
        bus1.iBranchTaken = 1'b1; bus1.iBranchTarget = 16'h0040;
        nedge(1);
        bus1.iBranchTaken = 1'b0;
        chk("br_valid", 64'(bus1.oValid), 64'd0);
        chk("br_romaddr", 64'(bus1.oRomAddress), 64'h0040);
        nedge(1);
        chk("br_pc", 64'(bus1.oPC), 64'h0040);
        chk("br_instr", 64'(bus1.oInstruction), 64'h25A0040);
        nedge(1);
        chk("br_pc_next", 64'(bus1.oPC), 64'h0041);

        // HALT at address 4, entered via branch to 0
        halt_en = 1'b1;
        bus1.iBranchTaken = 1'b1; bus1.iBranchTarget = 16'd0;
        nedge(1);
        bus1.iBranchTaken = 1'b0;
        nedge(5);
        chk("halt_pc", 64'(bus1.oPC), 64'd4);
        chk("halt_instr", 64'(bus1.oInstruction), 64'hF5A0004);
        chk("halt_romaddr", 64'(bus1.oRomAddress), 64'd4);
        for (int i = 0; i < 5; i++) begin
            nedge(1);
            chk("halted", 64'(bus1.oHalted), 64'd1);
            chk("halted_valid", 64'(bus1.oValid), 64'd0);
            chk("halted_romaddr", 64'(bus1.oRomAddress), 64'd4);
        end
        bus1.iBranchTaken = 1'b1; bus1.iBranchTarget = 16'd0;
        nedge(1);
        bus1.iBranchTaken = 1'b0;
        chk("restart_halted", 64'(bus1.oHalted), 64'd0);
        nedge(1);
        chk("restart_pc", 64'(bus1.oPC), 64'd0);
        chk("restart_valid", 64'(bus1.oValid), 64'd1);
        nedge(4);
        chk("drain_pc", 64'(bus1.oPC), 64'd4);

        // two-cycle stall in DRAIN, then asynchronous reset
        bus1.iReady = 1'b0;
        nedge(2);
        chk("drain_hold_pc", 64'(bus1.oPC), 64'd4);
        chk("drain_hold_valid", 64'(bus1.oValid), 64'd1);
        chk("drain_not_halted", 64'(bus1.oHalted), 64'd0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_drain");
        @(posedge clk); #2 rst = 1'b0;
        bus1.iReady = 1'b1;
        nedge(2);
        chk("rerun_idle", 64'(bus1.oValid), 64'd0);
        nedge(1);
        chk("rerun_pc", 64'(bus1.oPC), 64'd0);
        chk("rerun_valid", 64'(bus1.oValid), 64'd1);
        nedge(1);
        chk("addr6_never", 64'(seen6), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_sequencer.md
INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 16'd0: first ROM address fetched after reset.
REQ-002 Parameter HALT_OPCODE, default 4'hF: opcode value in bits [27:24] that stops fetching.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 oRomAddress  output  16  combinational ROM address; equals internal PC.
REQ-006 iRomInstruction  input  28  combinational ROM data for oRomAddress.
REQ-007 oInstruction  output  28  registered instruction presented to decode.
REQ-008 oPC  output  16  ROM address of oInstruction.
REQ-009 oValid  output  1  oInstruction/oPC are valid.
REQ-010 iReady  input  1  decode accepts oInstruction this cycle.
REQ-011 iBranchTaken  input  1  redirect fetch this cycle.
REQ-012 iBranchTarget  input  16  redirect address.
REQ-013 oHalted  output  1  sequencer in HALTED state.
REQ-014 oFetchCount, oStallCount  output  32 each  performance counters (see Configuration).

Function
REQ-015 The sequencer SHALL implement states IDLE, RUN, DRAIN, HALTED.
REQ-016 IDLE SHALL last exactly one cycle after Reset deasserts, with oValid=0, then go to RUN.
REQ-017 In RUN, when oValid=0 or iReady=1, the sequencer SHALL load oInstruction<=iRomInstruction, oPC<=PC, oValid<=1, PC<=PC+1 in the same cycle.
REQ-018 In RUN with oValid=1 and iReady=0, oInstruction, oPC, PC SHALL hold (no fetch, no drop).
REQ-019 PC increment SHALL wrap 16'hFFFF -> 16'h0000 with no status flag.
REQ-020 iBranchTaken SHALL override all other actions: PC<=iBranchTarget, oValid<=0, next state RUN, from any state except IDLE (where it is ignored).
REQ-021 When branch and iReady coincide, the presented instruction SHALL count as accepted; no stale instruction SHALL appear after the branch cycle.
REQ-022 Loading an instruction with opcode HALT_OPCODE SHALL move RUN -> DRAIN; PC SHALL not increment on that load.
REQ-023 In DRAIN, no further fetch SHALL occur; on oValid&&iReady, oValid<=0 and state -> HALTED.
REQ-024 In HALTED, oHalted=1, oValid=0, PC frozen; only iBranchTaken or Reset leaves HALTED.
REQ-025 First valid instruction SHALL appear 2 cycles after Reset deasserts (IDLE, then load); steady-state throughput one instruction per cycle with iReady=1.

Reset
REQ-026 Reset SHALL asynchronously force: state IDLE, PC=RESET_VECTOR, oValid=0, oInstruction=28'd0, oPC=16'd0, oHalted=0, both counters 0.
REQ-027 Reset asserted mid-DRAIN or mid-stall SHALL discard the held instruction with no further handshake.

Configuration
REQ-028 Macro IFETCH_PERF_CNT_EN defined: oFetchCount SHALL increment on every oValid&&iReady; oStallCount SHALL increment every cycle with oValid&&!iReady; both saturate at 32'hFFFFFFFF.
REQ-029 Macro IFETCH_PERF_CNT_EN undefined: both ports SHALL remain present and be tied to 32'd0, with no counter registers.

Structure
REQ-030 Opcode constants (NOP, STO, ADD, SUB, LED, HALT) and the opcode field position [27:24] SHALL live in the shared definitions file/package, not in this module.
REQ-031 State encoding SHALL be a localparam set in this module; no sub-module is required, the ROM is instantiated alongside, not inside.

Verification
REQ-032 Reset release, iReady=1, ROM linear program -> oValid rises cycle 2, oPC=0,1,2,3 on consecutive cycles.
REQ-033 iReady low for 3 cycles while oPC=2 -> oInstruction/oPC hold at address 2, oStallCount +3, resumes with oPC=3.
REQ-034 iBranchTaken=1, iBranchTarget=16'h0040 while oPC=5 valid -> next cycle oValid=0, following cycle oPC=16'h0040; address 6 never presented.
REQ-035 HALT opcode at address 4 -> oPC=4 presented, oRomAddress stays 4, after acceptance oHalted=1, oValid=0 indefinitely; branch to 0 restarts at oPC=0.
REQ-036 RESET_VECTOR=16'hFFFE -> oPC sequence FFFE, FFFF, 0000.
REQ-037 Reset pulsed during 2-cycle stall in DRAIN -> all outputs at reset values immediately, oFetchCount=0.
